// File: rtl/serial_addsub.sv
// serial_addsub: digit-serial adder/subtractor.
// A DIGIT-bit ripple slice of full-adder cells is reused for K = WIDTH/DIGIT
// cycles, with the inter-digit carry held in a flop. The operand side and the
// result side each use a valid/ready handshake.
// WIDTH must be >= 2 and DIGIT must divide WIDTH.
module serial_addsub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int K     = WIDTH / DIGIT;
  // One spare bit so the count never wraps inside an operation.
  localparam int CNT_W = $clog2(K) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(K - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] work_nxt;
  logic             a_msb;
  logic             beff_msb;
  logic [DIGIT-1:0] dsum;
  logic             dcout;
  logic             accept;
  logic             last_digit;

  // One full-adder cell: returns {carry_out, sum}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
    return {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
  endfunction

  assign accept     = in_valid && (state == IDLE);
  assign last_digit = (state == RUN) && (cnt == LAST);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; DONE never bypasses straight to a new accept.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)   state_nxt = RUN;
      RUN:     if (last_digit) state_nxt = DONE;
      DONE:    if (out_ready)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Ripple slice over the current low digit of the shifted operands.
  always_comb begin
    logic       c;
    logic [1:0] fa;
    c    = carry;
    fa   = '0;
    dsum = '0;
    for (int i = 0; i < DIGIT; i++) begin
      fa      = full_add(a_sh[i], b_sh[i], c);
      dsum[i] = fa[0];
      c       = fa[1];
    end
    dcout = c;
  end

  // New digit enters at the top; after K digits the whole result is aligned.
  always_comb begin
    work_nxt = (work >> DIGIT) | (WIDTH'(dsum) << (WIDTH - DIGIT));
  end

  // Operand shifters and partial-result accumulator; fully overwritten per op.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_sh     <= a;
      b_sh     <= b ^ {WIDTH{sub}};
      a_msb    <= a[WIDTH-1];
      beff_msb <= b[WIDTH-1] ^ sub;
    end else if (state == RUN) begin
      a_sh <= a_sh >> DIGIT;
      b_sh <= b_sh >> DIGIT;
      work <= work_nxt;
    end
  end

  // Digit counter, carry flop and the visible result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      cnt   <= '0;
      carry <= cin ^ sub;
    end else if (state == RUN) begin
      cnt   <= cnt + 1'b1;
      carry <= dcout;
      if (last_digit) begin
        sum  <= work_nxt;
        cout <= dcout;
        ovf  <= (a_msb == beff_msb) && (dsum[DIGIT-1] != a_msb);
      end
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Testbench for serial_addsub: a WIDTH=8/DIGIT=1 instance and a
// WIDTH=8/DIGIT=4 instance. Stimulus pushes expected results into a queue per
// instance; a monitor per instance compares whenever out_valid is high.
module tb_serial_addsub;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       cin = 1'b0;
  logic       sub = 1'b0;
  logic       out_ready = 1'b1;
  logic       iv1 = 1'b0;
  logic       iv4 = 1'b0;

  logic       ir1, ov1, co1, of1;
  logic [7:0] s1;
  logic       ir4, ov4, co4, of4;
  logic [7:0] s4;

  serial_addsub #(.WIDTH(8), .DIGIT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(ov1), .out_ready(out_ready),
    .sum(s1), .cout(co1), .ovf(of1)
  );

  serial_addsub #(.WIDTH(8), .DIGIT(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(ov4), .out_ready(out_ready),
    .sum(s4), .cout(co4), .ovf(of4)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [7:0] s;
    logic       c;
    logic       o;
    int         acc;
  } exp_t;

  exp_t q1[$];
  exp_t q4[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Monitor for the DIGIT=1 instance (K=8).
  logic ov1_d = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      ov1_d <= 1'b0;
    end else begin
      if (ov1) begin
        if (q1.size() == 0) begin
          chk("unexpected_out_d1", 32'd1, 32'd0);
        end else begin
          if (!ov1_d) chk("latency_d1", cyc - q1[0].acc, 32'd8);
          chk("sum_d1", {24'd0, s1}, {24'd0, q1[0].s});
          chk("cout_d1", {31'd0, co1}, {31'd0, q1[0].c});
          chk("ovf_d1", {31'd0, of1}, {31'd0, q1[0].o});
          chk("in_ready_done_d1", {31'd0, ir1}, 32'd0);
          if (out_ready) void'(q1.pop_front());
        end
      end
      ov1_d <= ov1;
    end
  end

  // Monitor for the DIGIT=4 instance (K=2).
  logic ov4_d = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      ov4_d <= 1'b0;
    end else begin
      if (ov4) begin
        if (q4.size() == 0) begin
          chk("unexpected_out_d4", 32'd1, 32'd0);
        end else begin
          if (!ov4_d) chk("latency_d4", cyc - q4[0].acc, 32'd2);
          chk("sum_d4", {24'd0, s4}, {24'd0, q4[0].s});
          chk("cout_d4", {31'd0, co4}, {31'd0, q4[0].c});
          chk("ovf_d4", {31'd0, of4}, {31'd0, q4[0].o});
          if (out_ready) void'(q4.pop_front());
        end
      end
      ov4_d <= ov4;
    end
  end

  // Present an operand set to instance id and wait (bounded) for its accept edge.
  task automatic issue(input int id, input logic [7:0] ia, input logic [7:0] ib,
                       input logic ic, input logic is, input logic [7:0] es,
                       input logic ec, input logic eo, input bit push, output int acc);
    int n;
    n = 0;
    acc = -1;
    @(negedge clk);
    a = ia; b = ib; cin = ic; sub = is;
    if (id == 1) iv1 = 1'b1; else iv4 = 1'b1;
    while (!((id == 1) ? ir1 : ir4)) begin
      @(negedge clk);
      n++;
      if (n > 100) begin
        chk("accept_timeout", 32'd0, 32'd1);
        iv1 = 1'b0; iv4 = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    acc = cyc;
    if (push) begin
      if (id == 1) q1.push_back('{es, ec, eo, acc});
      else         q4.push_back('{es, ec, eo, acc});
    end
    iv1 = 1'b0; iv4 = 1'b0;
  endtask

  // Wait (bounded) until every expected result has been consumed.
  task automatic drain();
    int n;
    n = 0;
    while ((q1.size() != 0 || q4.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("drain_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  initial begin
    int acc1, acc2, n;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", {31'd0, ov1}, 32'd0);
    chk("rst_sum", {24'd0, s1}, 32'd0);
    chk("rst_cout", {31'd0, co1}, 32'd0);
    chk("rst_ovf", {31'd0, of1}, 32'd0);
    chk("rst_in_ready", {31'd0, ir1}, 32'd1);
    chk("rst_out_valid_d4", {31'd0, ov4}, 32'd0);
    chk("rst_in_ready_d4", {31'd0, ir4}, 32'd1);
    rst_n = 1'b1;

    // Directed adds and subtracts, expected values worked by hand.
    issue(1, 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1, 1'b1, acc1); drain();
    issue(1, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, acc1); drain();
    issue(1, 8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1, 1'b1, acc1); drain();
    issue(1, 8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0, 1'b1, acc1); drain();
    issue(1, 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b1, acc1); drain();
    issue(1, 8'h05, 8'h02, 1'b1, 1'b1, 8'h02, 1'b1, 1'b0, 1'b1, acc1); drain();

    // Back-to-back operands with the consumer always ready: spacing is K+2.
    issue(1, 8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0, 1'b1, acc1);
    issue(1, 8'h03, 8'h04, 1'b0, 1'b0, 8'h07, 1'b0, 1'b0, 1'b1, acc2);
    chk("min_spacing", acc2 - acc1, 32'd10);
    drain();

    // Backpressure: result held in DONE for 5 cycles while inputs churn.
    @(posedge clk); #1 out_ready = 1'b0;
    issue(1, 8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0, 1'b1, acc1);
    n = 0;
    while (!ov1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_reached_done", {31'd0, ov1}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a = 8'($urandom); b = 8'($urandom); iv1 = ~iv1; cin = ~cin; sub = ~sub;
    end
    @(posedge clk); #1 out_ready = 1'b1;
    issue(1, 8'h20, 8'h22, 1'b0, 1'b0, 8'h42, 1'b0, 1'b0, 1'b1, acc2);
    // Accept edge acc1; DONE after acc1+8; held through edges acc1+9..acc1+14;
    // handshake at acc1+15; earliest re-accept at acc1+16.
    chk("bp_spacing", acc2 - acc1, 32'd16);
    drain();

    // Asynchronous reset three cycles into RUN aborts the operation.
    issue(1, 8'hFF, 8'hFF, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, acc1);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_out_valid", {31'd0, ov1}, 32'd0);
    chk("abort_sum", {24'd0, s1}, 32'd0);
    chk("abort_in_ready", {31'd0, ir1}, 32'd1);
    chk("abort_cout", {31'd0, co1}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(1, 8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0, 1'b1, acc1); drain();

    // DIGIT=4 instance.
    issue(4, 8'h9F, 8'h71, 1'b0, 1'b0, 8'h10, 1'b1, 1'b0, 1'b1, acc1); drain();
    issue(4, 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b1, acc1); drain();
    issue(4, 8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1, 1'b1, acc1); drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
